// File: rtl/bitwise_logic_unit_pkg.sv
// Shared opcode and FSM-state definitions for the bitwise logic unit.
// No logic of its own; no latency.
// No flow control here; imported by the unit, its chunk operator and the bench.
package bitwise_logic_unit_pkg;

    // 3-bit operation select carried on the request bus.
    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NAND  = 3'b011,
        OP_NOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_PASSA = 3'b110,
        OP_NOTA  = 3'b111
    } op_e;

    // Sequencer states: accept, walk the chunks, present the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// Request/response bus of the bitwise logic unit (operands in, result + flags out).
// Pure wiring; no latency.
// Valid/ready on both sides: in_valid/in_ready for requests, out_valid/out_ready for results.
interface bitwise_logic_unit_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;

    // Requester / result consumer side.
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, parity
    );

    // Logic unit side.
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, parity
    );

endinterface

// File: rtl/bitwise_logic_unit_logic_chunk.sv
// Combinational bitwise operator on one CHUNK-wide slice of the operands.
// Zero latency (pure combinational).
// No flow control; the sequencer decides when the output is captured.
module logic_chunk
    import bitwise_logic_unit_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [2:0]       op,
    output logic [CHUNK-1:0] y
);

    // Decode the operation; every bit is independent so there are no carries.
    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XNOR:  y = ~(a ^ b);
            OP_PASSA: y = a;
            OP_NOTA:  y = ~a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Bitwise logic unit: applies one of 8 bitwise ops to WIDTH-bit operands, CHUNK bits per cycle.
// out_valid rises N = WIDTH/CHUNK cycles after the accepting edge; one request in flight at a time.
// in_ready only while idle; result/zero/parity hold in DONE until out_ready, so back-to-back spacing is N+2.
module bitwise_logic_unit
    import bitwise_logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    bitwise_logic_unit_if.slave bus
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_parity;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [BW-1:0]    w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_y;

    // Bit offset of the chunk being processed this cycle.
    assign w_base    = BW'(int'(r_k) * CHUNK);
    assign w_a_chunk = r_a[w_base +: CHUNK];
    assign w_b_chunk = r_b[w_base +: CHUNK];

    logic_chunk #(
        .CHUNK (CHUNK)
    ) u_logic_chunk (
        .a  (w_a_chunk),
        .b  (w_b_chunk),
        .op (r_op),
        .y  (w_y)
    );

    // Sequencer: latch a request, write one result chunk per cycle, then hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 3'b000;
            r_k         <= '0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_parity    <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_op       <= bus.op;
                        r_k        <= '0;
                        r_zero     <= 1'b1;
                        r_parity   <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_result[w_base +: CHUNK] <= w_y;
                    r_zero   <= r_zero & ~(|w_y);
                    r_parity <= r_parity ^ (^w_y);
                    // Counter parks on the last chunk rather than wrapping.
                    if (r_k == K_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Ready is only honoured here; the freed slot opens on the following edge.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.parity    = r_parity;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed bench for bitwise_logic_unit in three geometries: 32/8, 64/64 and 16/4.
// Inputs are driven and outputs sampled 1ns after the rising edge.
// Each scenario task performs its own comparisons against hand-computed values.
module tb_bitwise_logic_unit;
    import bitwise_logic_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit_if #(.WIDTH(32)) bus0 ();
    bitwise_logic_unit_if #(.WIDTH(64)) bus1 ();
    bitwise_logic_unit_if #(.WIDTH(16)) bus2 ();

    bitwise_logic_unit #(.WIDTH(32), .CHUNK(8))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    bitwise_logic_unit #(.WIDTH(64), .CHUNK(64)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    bitwise_logic_unit #(.WIDTH(16), .CHUNK(4))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Present one request to dut0 for one edge, then scramble the inputs while it is busy.
    task automatic send0(input logic [2:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b);
        bus0.op = f_op; bus0.a = f_a; bus0.b = f_b; bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0; bus0.op = ~f_op; bus0.a = ~f_a; bus0.b = ~f_b;
    endtask

    // Count edges from acceptance until dut0 shows out_valid; -1 if the budget expires.
    task automatic wait0(output int lat);
        int c;
        lat = -1; c = 0;
        while (lat < 0 && c < 20) begin
            @(posedge clk); #1; c++;
            if (bus0.out_valid) lat = c;
        end
    endtask

    task automatic consume0();
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus0.in_ready !== 1'b1)      begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus0.in_ready); end
        n_cmp++; if (bus0.out_valid !== 1'b0)     begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus0.out_valid); end
        n_cmp++; if (bus0.result !== 32'h0)       begin n_err++; $display("FAIL rst_result: got %h want 0", bus0.result); end
        n_cmp++; if (bus0.zero !== 1'b1)          begin n_err++; $display("FAIL rst_zero: got %b want 1", bus0.zero); end
        n_cmp++; if (bus0.parity !== 1'b0)        begin n_err++; $display("FAIL rst_parity: got %b want 0", bus0.parity); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus0.in_ready !== 1'b1)      begin n_err++; $display("FAIL rel_in_ready: got %b want 1", bus0.in_ready); end
        n_cmp++; if (bus0.out_valid !== 1'b0)     begin n_err++; $display("FAIL rel_out_valid: got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_xor();
        int lat;
        send0(OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F);
        n_cmp++; if (bus0.in_ready !== 1'b0)      begin n_err++; $display("FAIL xor_busy_in_ready: got %b want 0", bus0.in_ready); end
        wait0(lat);
        n_cmp++; if (lat !== 4)                   begin n_err++; $display("FAIL xor_latency: got %0d want 4", lat); end
        n_cmp++; if (bus0.result !== 32'hF0F00F0F) begin n_err++; $display("FAIL xor_result: got %h want f0f00f0f", bus0.result); end
        n_cmp++; if (bus0.zero !== 1'b0)          begin n_err++; $display("FAIL xor_zero: got %b want 0", bus0.zero); end
        n_cmp++; if (bus0.parity !== 1'b0)        begin n_err++; $display("FAIL xor_parity: got %b want 0", bus0.parity); end
        consume0();
        n_cmp++; if (bus0.out_valid !== 1'b0)     begin n_err++; $display("FAIL xor_after_valid: got %b want 0", bus0.out_valid); end
        n_cmp++; if (bus0.in_ready !== 1'b1)      begin n_err++; $display("FAIL xor_after_ready: got %b want 1", bus0.in_ready); end
    endtask

    task automatic test_backpressure();
        int lat;
        send0(OP_AND, 32'hAAAAAAAA, 32'h55555555);
        wait0(lat);
        n_cmp++; if (lat !== 4)                   begin n_err++; $display("FAIL and_latency: got %0d want 4", lat); end
        n_cmp++; if (bus0.result !== 32'h0)       begin n_err++; $display("FAIL and_result: got %h want 0", bus0.result); end
        n_cmp++; if (bus0.zero !== 1'b1)          begin n_err++; $display("FAIL and_zero: got %b want 1", bus0.zero); end
        n_cmp++; if (bus0.parity !== 1'b0)        begin n_err++; $display("FAIL and_parity: got %b want 0", bus0.parity); end
        // A competing request during DONE must be ignored.
        bus0.in_valid = 1'b1; bus0.op = OP_OR; bus0.a = 32'hFFFFFFFF; bus0.b = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus0.out_valid); end
            n_cmp++; if (bus0.result !== 32'h0 || bus0.zero !== 1'b1) begin n_err++; $display("FAIL hold_result[%0d]: got %h/%b want 0/1", i, bus0.result, bus0.zero); end
            n_cmp++; if (bus0.in_ready !== 1'b0)  begin n_err++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, bus0.in_ready); end
        end
        bus0.in_valid = 1'b0;
        consume0();
        n_cmp++; if (bus0.out_valid !== 1'b0)     begin n_err++; $display("FAIL and_after_valid: got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_early_ready();
        int lat;
        // out_ready high throughout BUSY; the result must still arrive on time and show for one cycle.
        bus0.out_ready = 1'b1;
        send0(OP_XNOR, 32'h0000FFFF, 32'h00FF00FF);
        wait0(lat);
        n_cmp++; if (lat !== 4)                   begin n_err++; $display("FAIL early_latency: got %0d want 4", lat); end
        n_cmp++; if (bus0.result !== 32'hFF0000FF) begin n_err++; $display("FAIL early_result: got %h want ff0000ff", bus0.result); end
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        n_cmp++; if (bus0.out_valid !== 1'b0)     begin n_err++; $display("FAIL early_consumed: got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r [8];
        logic [2:0]  ops   [8];
        int idx, got, last_acc, cyc;
        logic acc;
        ops   = '{OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_PASSA, OP_NOTA};
        exp_r = '{32'h00005678, 32'h1234FFFF, 32'h1234A987, 32'hFFFFA987,
                  32'hEDCB0000, 32'hEDCB5678, 32'h12345678, 32'hEDCBA987};
        idx = 0; got = 0; last_acc = -1; cyc = 0;
        bus0.a = 32'h12345678; bus0.b = 32'h0000FFFF; bus0.op = ops[0];
        bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
        while (got < 8 && cyc < 150) begin
            acc = bus0.in_ready && (idx < 8);
            @(posedge clk); #1; cyc++;
            if (acc) begin
                if (last_acc >= 0) begin
                    n_cmp++; if (cyc - last_acc != 6) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want 6", idx, cyc - last_acc); end
                end
                last_acc = cyc; idx++;
                if (idx < 8) bus0.op = ops[idx]; else bus0.in_valid = 1'b0;
            end
            if (bus0.out_valid) begin
                n_cmp++; if (bus0.result !== exp_r[got]) begin n_err++; $display("FAIL b2b_result[%0d]: got %h want %h", got, bus0.result, exp_r[got]); end
                n_cmp++; if (bus0.parity !== ^exp_r[got]) begin n_err++; $display("FAIL b2b_parity[%0d]: got %b want %b", got, bus0.parity, ^exp_r[got]); end
                n_cmp++; if (bus0.zero !== (exp_r[got] == 32'h0)) begin n_err++; $display("FAIL b2b_zero[%0d]: got %b want %b", got, bus0.zero, exp_r[got] == 32'h0); end
                got++;
            end
        end
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        n_cmp++; if (got != 8) begin n_err++; $display("FAIL b2b_results: got %0d want 8", got); end
        n_cmp++; if (idx != 8) begin n_err++; $display("FAIL b2b_accepts: got %0d want 8", idx); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        send0(OP_NOR, 32'h0F0F0F0F, 32'h00000000);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_flags: got v=%b r=%b want v=0 r=1", bus0.out_valid, bus0.in_ready); end
        n_cmp++; if (bus0.result !== 32'h0 || bus0.zero !== 1'b1) begin n_err++; $display("FAIL midrst_result: got %h/%b want 0/1", bus0.result, bus0.zero); end
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (bus0.out_valid) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_ghost: got out_valid=%b want 0", seen); end
        send0(OP_OR, 32'h00000001, 32'h00000002);
        wait0(lat);
        n_cmp++; if (lat !== 4)                   begin n_err++; $display("FAIL or_latency: got %0d want 4", lat); end
        n_cmp++; if (bus0.result !== 32'h3)       begin n_err++; $display("FAIL or_result: got %h want 3", bus0.result); end
        n_cmp++; if (bus0.parity !== 1'b0)        begin n_err++; $display("FAIL or_parity: got %b want 0", bus0.parity); end
        consume0();
    endtask

    task automatic test_single_chunk();
        int lat, c;
        bus1.op = OP_NOTA; bus1.a = 64'h0; bus1.b = 64'h0; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0; bus1.a = 64'hFFFF; bus1.op = OP_PASSA;
        lat = -1; c = 0;
        while (lat < 0 && c < 20) begin @(posedge clk); #1; c++; if (bus1.out_valid) lat = c; end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL n1_latency: got %0d want 1", lat); end
        n_cmp++; if (bus1.result !== 64'hFFFFFFFFFFFFFFFF) begin n_err++; $display("FAIL n1_result: got %h want all ones", bus1.result); end
        n_cmp++; if (bus1.parity !== 1'b0) begin n_err++; $display("FAIL n1_parity: got %b want 0", bus1.parity); end
        n_cmp++; if (bus1.zero !== 1'b0)   begin n_err++; $display("FAIL n1_zero: got %b want 0", bus1.zero); end
        bus1.out_ready = 1'b1; @(posedge clk); #1; bus1.out_ready = 1'b0;
    endtask

    task automatic test_narrow_parity();
        int lat, c;
        bus2.op = OP_PASSA; bus2.a = 16'h0001; bus2.b = 16'hFFFF; bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0; bus2.a = 16'h0003;
        lat = -1; c = 0;
        while (lat < 0 && c < 20) begin @(posedge clk); #1; c++; if (bus2.out_valid) lat = c; end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL w16_latency: got %0d want 4", lat); end
        n_cmp++; if (bus2.result !== 16'h0001) begin n_err++; $display("FAIL w16_result: got %h want 0001", bus2.result); end
        n_cmp++; if (bus2.parity !== 1'b1) begin n_err++; $display("FAIL w16_parity: got %b want 1", bus2.parity); end
        n_cmp++; if (bus2.zero !== 1'b0)   begin n_err++; $display("FAIL w16_zero: got %b want 0", bus2.zero); end
        bus2.out_ready = 1'b1; @(posedge clk); #1; bus2.out_ready = 1'b0;
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.op = 3'b000; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.op = 3'b000; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.op = 3'b000; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_xor();
        test_backpressure();
        test_early_ready();
        test_back_to_back();
        test_reset_mid();
        test_single_chunk();
        test_narrow_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
